// File: rtl/usb_tx_reader_pkg.sv
// Shared widths, FSM state codes and message-length helper for usb_tx_reader.
// Optional checksum trailer word is built when USB_TX_CSUM_EN is defined.
package usb_tx_reader_pkg;

    localparam int USB_DATA_NBIT     = 16;
    localparam int BUFFER_ADDR_NBIT  = 8;
    localparam int BUFFER_BADDR_NBIT = 2;
    localparam int TX_HS_LEN         = 4;

    typedef enum logic [2:0] {
        ST_TX_IDLE,
        ST_TX_READ,
        ST_TX_DRAIN,
        ST_TX_CSUM,
        ST_TX_PKTEND
    } tx_state_t;

    // Base 0 holds the short handshake reply; any other base is a full ADC page.
    function automatic int tx_msg_len(
        input int baddr,
        input int addr_nbit,
        input int hs_len
    );
        return (baddr == 0) ? hs_len : (1 << addr_nbit);
    endfunction

endpackage

// File: rtl/usb_tx_reader_skid.sv
// tx_skid_fifo: 2-entry register FIFO that absorbs the one-cycle buffer read latency.
// Caller guarantees no push when full and no pop when empty.
module tx_skid_fifo #(
    parameter int DATA_NBIT = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_push,
    input  logic                 i_pop,
    input  logic [DATA_NBIT-1:0] i_din,
    output logic [DATA_NBIT-1:0] o_dout,
    output logic                 o_empty,
    output logic [1:0]           o_cnt
);

    logic [DATA_NBIT-1:0] r_mem [2];
    logic                 r_wptr;
    logic                 r_rptr;
    logic [1:0]           r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 2; i++) r_mem[i] <= '0;
            r_wptr <= 1'b0;
            r_rptr <= 1'b0;
            r_cnt  <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wptr] <= i_din;
                r_wptr        <= ~r_wptr;
            end
            if (i_pop) r_rptr <= ~r_rptr;
            unique case ({i_push, i_pop})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign o_dout  = r_mem[r_rptr];
    assign o_empty = (r_cnt == 2'd0);
    assign o_cnt   = r_cnt;

endmodule

// File: rtl/usb_tx_reader.sv
// usb_tx_reader: streams completed TX buffers into the USB slave FIFO, then pktend.
// Define USB_TX_CSUM_EN to append a 16-bit modulo-sum word to every packet.
module usb_tx_reader
    import usb_tx_reader_pkg::*;
#(
    parameter int DATA_NBIT  = USB_DATA_NBIT,
    parameter int ADDR_NBIT  = BUFFER_ADDR_NBIT,
    parameter int BADDR_NBIT = BUFFER_BADDR_NBIT,
    parameter int HS_LEN     = TX_HS_LEN
) (
    input  logic                            i_mclk,
    input  logic                            i_rst_n,
    input  logic                            i_msg_done,
    input  logic [BADDR_NBIT-1:0]           i_msg_baddr,
    output logic                            o_buf_rd,
    output logic [BADDR_NBIT+ADDR_NBIT-1:0] o_buf_addr,
    input  logic [DATA_NBIT-1:0]            i_buf_data,
    input  logic                            i_usb_full,
    output logic                            o_usb_wr,
    output logic [DATA_NBIT-1:0]            o_usb_data,
    output logic                            o_usb_pktend,
    output logic                            o_busy,
    output logic                            o_ovf_err
);

    localparam int LEN_NBIT = ADDR_NBIT + 1;

    tx_state_t             r_state;
    logic [BADDR_NBIT-1:0] r_baddr;
    logic [ADDR_NBIT-1:0]  r_addr;
    logic [LEN_NBIT-1:0]   r_len;
    logic [LEN_NBIT-1:0]   r_rd_cnt;
    logic                  r_inflight;
    logic                  r_pend_v;
    logic [BADDR_NBIT-1:0] r_pend_baddr;
    logic                  r_ovf;

    logic [DATA_NBIT-1:0]  w_skid_dout;
    logic                  w_skid_empty;
    logic [1:0]            w_skid_cnt;
    logic                  w_pop;
    logic [2:0]            w_used;
    logic [2:0]            w_cap;
    logic                  w_rd;
    logic                  w_last_rd;
    logic                  w_drained;
    logic                  w_idle;
    logic                  w_start;
    logic [BADDR_NBIT-1:0] w_start_baddr;
    logic [LEN_NBIT-1:0]   w_start_len;

    tx_skid_fifo #(
        .DATA_NBIT (DATA_NBIT)
    ) u_skid (
        .i_clk   (i_mclk),
        .i_rst_n (i_rst_n),
        .i_push  (r_inflight),
        .i_pop   (w_pop),
        .i_din   (i_buf_data),
        .o_dout  (w_skid_dout),
        .o_empty (w_skid_empty),
        .o_cnt   (w_skid_cnt)
    );

    // A pop this cycle frees a slot for the read issued now: 1 word/cycle.
    always_comb begin
        w_pop         = !w_skid_empty && !i_usb_full;
        w_used        = {1'b0, w_skid_cnt} + {2'b00, r_inflight};
        w_cap         = 3'd2 + {2'b00, w_pop};
        w_rd          = (r_state == ST_TX_READ) && (w_used < w_cap);
        w_last_rd     = w_rd && (r_rd_cnt == r_len - LEN_NBIT'(1));
        w_drained     = !r_inflight &&
                        (w_skid_empty || (w_skid_cnt == 2'd1 && w_pop));
        w_idle        = (r_state == ST_TX_IDLE);
        w_start       = w_idle && (r_pend_v || i_msg_done);
        w_start_baddr = r_pend_v ? r_pend_baddr : i_msg_baddr;
        w_start_len   = LEN_NBIT'(tx_msg_len(int'(w_start_baddr),
                                             ADDR_NBIT, HS_LEN));
    end

    assign o_buf_rd     = w_rd;
    assign o_buf_addr   = {r_baddr, r_addr};
    assign o_busy       = !w_idle;
    assign o_usb_pktend = (r_state == ST_TX_PKTEND);
    assign o_ovf_err    = r_ovf;

`ifdef USB_TX_CSUM_EN
    logic [DATA_NBIT-1:0] r_sum;
    logic                 w_csum_st;

    assign w_csum_st  = (r_state == ST_TX_CSUM);
    assign o_usb_wr   = w_pop || (w_csum_st && !i_usb_full);
    assign o_usb_data = w_csum_st ? r_sum : w_skid_dout;

    always_ff @(posedge i_mclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sum <= '0;
        end else if (w_start) begin
            r_sum <= '0;
        end else if (w_pop) begin
            r_sum <= r_sum + w_skid_dout;
        end
    end
`else
    assign o_usb_wr   = w_pop;
    assign o_usb_data = w_skid_dout;
`endif

    always_ff @(posedge i_mclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_TX_IDLE;
            r_baddr      <= '0;
            r_addr       <= '0;
            r_len        <= '0;
            r_rd_cnt     <= '0;
            r_inflight   <= 1'b0;
            r_pend_v     <= 1'b0;
            r_pend_baddr <= '0;
            r_ovf        <= 1'b0;
        end else begin
            r_inflight <= w_rd;
            r_ovf      <= 1'b0;

            // Pending slot frees in IDLE, so a same-cycle msg_done refills it.
            if (w_idle) begin
                if (r_pend_v && !i_msg_done) begin
                    r_pend_v <= 1'b0;
                end else if (r_pend_v) begin
                    r_pend_baddr <= i_msg_baddr;
                end
            end else if (i_msg_done) begin
                if (r_pend_v) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_pend_v     <= 1'b1;
                    r_pend_baddr <= i_msg_baddr;
                end
            end

            if (w_rd) begin
                r_addr   <= r_addr + ADDR_NBIT'(1);
                r_rd_cnt <= r_rd_cnt + LEN_NBIT'(1);
            end

            unique case (r_state)
                ST_TX_IDLE: begin
                    if (w_start) begin
                        r_baddr  <= w_start_baddr;
                        r_len    <= w_start_len;
                        r_addr   <= '0;
                        r_rd_cnt <= '0;
                        r_state  <= ST_TX_READ;
                    end
                end
                ST_TX_READ: begin
                    if (w_last_rd) r_state <= ST_TX_DRAIN;
                end
                ST_TX_DRAIN: begin
`ifdef USB_TX_CSUM_EN
                    if (w_drained) r_state <= ST_TX_CSUM;
`else
                    if (w_drained) r_state <= ST_TX_PKTEND;
`endif
                end
`ifdef USB_TX_CSUM_EN
                ST_TX_CSUM: begin
                    if (!i_usb_full) r_state <= ST_TX_PKTEND;
                end
`endif
                ST_TX_PKTEND: begin
                    r_state <= ST_TX_IDLE;
                end
                default: begin
                    r_state <= ST_TX_IDLE;
                end
            endcase
        end
    end

endmodule
